// File: rtl/ei_axi4_slave_pkg.sv
// Shared types, response codes and state encodings for the AXI4 slave memory.
package ei_axi4_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Write FSM state encoding
    typedef logic [1:0] w_state_t;
    localparam w_state_t W_IDLE = 2'd0;
    localparam w_state_t W_DATA = 2'd1;
    localparam w_state_t W_RESP = 2'd2;

    // Read FSM state encoding
    typedef logic [0:0] r_state_t;
    localparam r_state_t R_IDLE = 1'b0;
    localparam r_state_t R_DATA = 1'b1;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ei_axi4_addr_gen.sv
// Combinational next-beat address and per-beat error calculation for one AXI path.
module ei_axi4_addr_gen
    import ei_axi4_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  err
);

    localparam int unsigned OFFS = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] incr;
    logic [31:0]           word_idx;

    // Next address per burst type, plus the error flag for the beat at addr
    always_comb begin
        step     = ADDR_WIDTH'(1) << size;
        span     = step * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        // span is a power of two whenever the WRAP length is legal
        mask     = span - ADDR_WIDTH'(1);
        incr     = addr + step;
        word_idx = 32'(addr >> OFFS);
        case (burst_e'(burst))
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) + (incr & mask);
            default:     next_addr = incr;
        endcase
        err = (burst_e'(burst) == BURST_RSVD) ||
              ((burst_e'(burst) == BURST_WRAP) && !wrap_len_ok(len)) ||
              (size != 3'(OFFS)) ||
              (word_idx >= 32'(MEM_DEPTH));
    end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs over a word-addressed RAM.
module ei_axi4_slave_mem
    import ei_axi4_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS   = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write path state
    w_state_t              w_state_q;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q;
    logic [7:0]            w_cnt_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q;
    logic                  w_err_q;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_gen_err;
    logic                  w_last_beat;
    logic                  w_beat_err;
    logic                  w_en;
    logic [IDX_W-1:0]      w_word;

    // Read path state; r_addr_q holds the address of the next beat to fetch
    r_state_t              r_state_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q;
    logic [7:0]            r_cnt_q;
    logic [2:0]            r_size_q;
    logic [1:0]            r_burst_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [ADDR_WIDTH-1:0] r_gen_addr;
    logic [7:0]            r_gen_len;
    logic [2:0]            r_gen_size;
    logic [1:0]            r_gen_burst;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic                  r_gen_err;
    logic                  r_fetch;
    logic [IDX_W-1:0]      r_word;

    ei_axi4_addr_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_w_addr_gen (
        .addr     (w_addr_q),
        .len      (w_len_q),
        .size     (w_size_q),
        .burst    (w_burst_q),
        .next_addr(w_next_addr),
        .err      (w_gen_err)
    );

    ei_axi4_addr_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_r_addr_gen (
        .addr     (r_gen_addr),
        .len      (r_gen_len),
        .size     (r_gen_size),
        .burst    (r_gen_burst),
        .next_addr(r_next_addr),
        .err      (r_gen_err)
    );

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = w_id_q;
    assign bresp   = w_err_q ? SLVERR : OKAY;

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = r_id_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    // Per-beat write qualification; a wlast mismatch poisons the beat it arrives on
    always_comb begin
        w_last_beat = (w_cnt_q == w_len_q);
        w_beat_err  = w_gen_err || (wlast != w_last_beat);
        w_en        = wready && wvalid && !areset && !w_err_q && !w_beat_err;
        w_word      = IDX_W'(w_addr_q >> OFFS);
    end

    // Read fetch source: AR fields for the first beat, latched fields afterwards
    always_comb begin
        if (r_state_q == R_IDLE) begin
            r_gen_addr  = araddr;
            r_gen_len   = arlen;
            r_gen_size  = arsize;
            r_gen_burst = arburst;
        end else begin
            r_gen_addr  = r_addr_q;
            r_gen_len   = r_len_q;
            r_gen_size  = r_size_q;
            r_gen_burst = r_burst_q;
        end
        r_fetch = ((r_state_q == R_IDLE) && arvalid) ||
                  ((r_state_q == R_DATA) && rready && !rlast_q);
        r_word  = IDX_W'(r_gen_addr >> OFFS);
    end

    // Write FSM: AW latch, beat counting with sticky error, B hold
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awvalid) begin
                        w_id_q    <= awid;
                        w_addr_q  <= awaddr;
                        w_len_q   <= awlen;
                        w_size_q  <= awsize;
                        w_burst_q <= awburst;
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_addr_q <= w_next_addr;
                        w_cnt_q  <= w_cnt_q + 8'd1;
                        w_err_q  <= w_err_q | w_beat_err;
                        if (w_last_beat) begin
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // RAM byte-lane writes; contents are deliberately not reset
    always_ff @(posedge aclk) begin
        if (w_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[w_word][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: beats are prefetched into the output register on each acceptance
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
        end else begin
            if (r_fetch) begin
                // Same-cycle write to this word lands after this read sample
                rdata_q <= r_gen_err ? '0 : mem[r_word];
                rresp_q <= r_gen_err ? SLVERR : OKAY;
                r_addr_q <= r_next_addr;
            end
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        r_id_q    <= arid;
                        r_len_q   <= arlen;
                        r_size_q  <= arsize;
                        r_burst_q <= arburst;
                        r_cnt_q   <= '0;
                        rlast_q   <= (arlen == 8'd0);
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_cnt_q <= r_cnt_q + 8'd1;
                            rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Randomised scoreboard bench for ei_axi4_slave_mem with a behavioural memory model.
module tb_ei_axi4_slave_mem;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int IW    = 4;
    localparam int DEPTH = 1024;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;

    ei_axi4_slave_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ID_WIDTH  (IW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0]   data;
        logic [1:0]    resp;
        logic          last;
        logic [IW-1:0] id;
    } r_exp_t;

    typedef struct packed {
        logic [1:0]    resp;
        logic [IW-1:0] id;
    } b_exp_t;

    r_exp_t      exp_r[$];
    b_exp_t      exp_b[$];
    logic [31:0] mem_model [DEPTH];
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];

    // Ready generation: random unless a directed test forces a value
    logic rr_force = 1'b0, rr_val = 1'b1, rr_rand = 1'b1;
    logic br_force = 1'b0, br_val = 1'b1, br_rand = 1'b1;
    assign rready = rr_force ? rr_val : rr_rand;
    assign bready = br_force ? br_val : br_rand;

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            rr_rand = ($urandom_range(0, 3) != 0);
            br_rand = ($urandom_range(0, 2) != 0);
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endfunction

    // Reference address sequence and error rules, straight from the burst definitions
    function automatic int unsigned next_addr_model(input int unsigned a, input int unsigned len,
                                                    input int unsigned size, input int unsigned burst);
        int unsigned b     = 1 << size;
        int unsigned total = b * (len + 1);
        if (burst == 0) return a;
        if (burst == 2) return ((a / total) * total + (a + b) % total) & 32'hFFFF;
        return (a + b) & 32'hFFFF;
    endfunction

    function automatic bit beat_err_model(input int unsigned a, input int unsigned len,
                                          input int unsigned size, input int unsigned burst);
        return (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15})) || (size != 2) ||
               ((a >> 2) >= DEPTH);
    endfunction

    // Monitor: pops expectations on handshakes and checks stall stability
    logic   r_stall = 1'b0, b_stall = 1'b0;
    r_exp_t r_saved;
    b_exp_t b_saved;
    initial begin
        r_exp_t re;
        b_exp_t be;
        forever begin
            @(negedge aclk);
            if (areset) begin
                r_stall = 1'b0;
                b_stall = 1'b0;
            end else begin
                if (r_stall) begin
                    chk("r_hold_valid", rvalid, 1);
                    chk("r_hold_payload", {rdata, rresp, rlast, rid}, r_saved);
                end
                if (b_stall) begin
                    chk("b_hold_valid", bvalid, 1);
                    chk("b_hold_payload", {bresp, bid}, b_saved);
                end
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) note_fail("r_unexpected_beat");
                    else begin
                        re = exp_r.pop_front();
                        chk("rdata", rdata, re.data);
                        chk("rresp", rresp, re.resp);
                        chk("rlast", rlast, re.last);
                        chk("rid", rid, re.id);
                    end
                end
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) note_fail("b_unexpected");
                    else begin
                        be = exp_b.pop_front();
                        chk("bresp", bresp, be.resp);
                        chk("bid", bid, be.id);
                    end
                end
                r_stall = rvalid && !rready;
                r_saved = {rdata, rresp, rlast, rid};
                b_stall = bvalid && !bready;
                b_saved = {bresp, bid};
            end
        end
    end

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return awready;
            1:       return wready;
            2:       return arready;
            3:       return bvalid;
            default: return rvalid;
        endcase
    endfunction

    // Wait (bounded) until the selected signal is seen high at a falling edge
    task automatic wait_until(input int sel, input string name);
        int n = 0;
        while (!sig_sel(sel)) begin
            @(negedge aclk);
            if (sig_sel(sel)) break;
            n++;
            if (n >= 300) begin
                note_fail(name);
                break;
            end
        end
    endtask

    task automatic handshake(input int sel, input string name);
        @(negedge aclk);
        wait_until(sel, name);
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (exp_r.size() != 0 || exp_b.size() != 0) begin
            note_fail(name);
            exp_r.delete();
            exp_b.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input int unsigned addr, input int unsigned len, input int unsigned size,
                            input int unsigned burst, input logic [IW-1:0] id, input int bad);
        int unsigned a = addr;
        bit err = 0;
        for (int i = 0; i <= int'(len); i++) begin
            err = err | beat_err_model(a, len, size, burst) | (i == bad);
            if (!err) begin
                for (int k = 0; k < 4; k++)
                    if (sbuf[i][k]) mem_model[a >> 2][8*k +: 8] = wbuf[i][8*k +: 8];
            end
            a = next_addr_model(a, len, size, burst);
        end
        exp_b.push_back('{resp: err ? 2'b10 : 2'b00, id: id});
        awid = id; awaddr = AW'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        handshake(0, "aw_timeout");
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge aclk);
                #1;
            end
            wdata = wbuf[i]; wstrb = sbuf[i];
            wlast = (i == int'(len)) ^ (i == bad);
            wvalid = 1'b1;
            handshake(1, "w_timeout");
            wvalid = 1'b0;
            wlast = 1'b0;
        end
        wait_drained("b_drain");
    endtask

    task automatic do_read(input int unsigned addr, input int unsigned len, input int unsigned size,
                           input int unsigned burst, input logic [IW-1:0] id);
        int unsigned a = addr;
        bit e;
        for (int i = 0; i <= int'(len); i++) begin
            e = beat_err_model(a, len, size, burst);
            exp_r.push_back('{data: e ? 32'h0 : mem_model[a >> 2], resp: e ? 2'b10 : 2'b00,
                              last: (i == int'(len)), id: id});
            a = next_addr_model(a, len, size, burst);
        end
        arid = id; araddr = AW'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        handshake(2, "ar_timeout");
        arvalid = 1'b0;
        wait_drained("r_drain");
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        int unsigned burst, len, size, addr;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Fill the whole RAM so every later read has a defined expectation
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wbuf[i] = $urandom;
                sbuf[i] = 4'hF;
            end
            do_write(blk * 1024, 255, 2, 1, 4'(blk), -1);
        end

        // INCR write then read back
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        do_write(32'h10, 3, 2, 1, 4'h3, -1);
        do_read(32'h10, 3, 2, 1, 4'h5);

        // WRAP read 0x38, 0x3C, 0x30, 0x34
        do_read(32'h38, 3, 2, 2, 4'h6);

        // Byte strobes
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(32'h0, 0, 2, 1, 4'h1, -1);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(32'h0, 0, 2, 1, 4'h2, -1);
        do_read(32'h0, 0, 2, 1, 4'h7);

        // Out-of-range write must not alias into low words
        wbuf[0] = 32'hDEAD0001; wbuf[1] = 32'hDEAD0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'h1000, 1, 2, 1, 4'h8, -1);
        do_read(32'h0, 1, 2, 1, 4'h9);
        do_read(32'h0FFC, 1, 2, 1, 4'hA);

        // rready low for 5 cycles after the first beat
        rr_force = 1'b1; rr_val = 1'b1;
        fork
            do_read(32'h100, 7, 2, 1, 4'hB);
            begin
                @(negedge aclk);
                wait_until(4, "rvalid_wait");
                @(posedge aclk);
                #1;
                rr_val = 1'b0;
                repeat (5) @(posedge aclk);
                #1;
                rr_val = 1'b1;
            end
        join
        rr_force = 1'b0;

        // bready low for 3 cycles
        br_force = 1'b1; br_val = 1'b0;
        wbuf[0] = 32'h5555AAAA; wbuf[1] = 32'hAAAA5555;
        fork
            do_write(32'h120, 1, 2, 1, 4'hC, -1);
            begin
                @(negedge aclk);
                wait_until(3, "bvalid_wait");
                repeat (3) @(posedge aclk);
                #1;
                br_val = 1'b1;
            end
        join
        br_force = 1'b0;

        // Same-word write and read accepted on the same edge: read sees old data
        old = mem_model[5];
        exp_r.push_back('{data: old, resp: 2'b00, last: 1'b1, id: 4'h2});
        exp_b.push_back('{resp: 2'b00, id: 4'h1});
        mem_model[5] = 32'hCAFEF00D;
        awid = 4'h1; awaddr = 16'h14; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        handshake(0, "aw_collide");
        awvalid = 1'b0;
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        arid = 4'h2; araddr = 16'h14; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        @(negedge aclk);
        chk("collide_ready", {wready, arready}, 2'b11);
        @(posedge aclk);
        #1;
        wvalid = 1'b0; arvalid = 1'b0; wlast = 1'b0;
        wait_drained("collide_drain");
        do_read(32'h14, 0, 2, 1, 4'h3);

        // Reset after beat 2 of a 4-beat write
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'hB0B00000 + i;
            sbuf[i] = 4'hF;
        end
        mem_model[32'h200 >> 2] = wbuf[0];
        mem_model[(32'h200 >> 2) + 1] = wbuf[1];
        awid = 4'h4; awaddr = 16'h200; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        handshake(0, "aw_rst");
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = wbuf[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            handshake(1, "w_rst");
        end
        wvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_awready", awready, 1);
        chk("midrst_wready", wready, 0);
        chk("midrst_bvalid", bvalid, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        do_read(32'h200, 3, 2, 1, 4'h5);
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        do_write(32'h200, 3, 2, 1, 4'h6, -1);
        do_read(32'h200, 3, 2, 1, 4'h7);

        // Randomised traffic
        for (int t = 0; t < 80; t++) begin
            burst = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
            if (burst == 2)
                len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15)
                                                  : (2 << $urandom_range(0, 3)) - 1;
            else
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
            size = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 2;
            addr = $urandom_range(0, 32'h10FF) & ~32'h3;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wbuf[i] = $urandom;
                    sbuf[i] = 4'($urandom_range(0, 15));
                end
                do_write(addr, len, size, burst, 4'($urandom), ($urandom_range(0, 9) == 0) ?
                         int'($urandom_range(0, len)) : -1);
            end else begin
                do_read(addr, len, size, burst, 4'($urandom));
            end
        end

        repeat (5) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
